// File: rtl/wb_port_arbiter.sv
// Writeback-stage owner of the single register-file write port: round-robin
// between ALU and load results, x0/flush suppression, and ECALL sequencing.
module wb_port_arbiter #(
    parameter int REGBITS = 5,
    parameter int LOGSIZE = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_valid,
    input  logic [REGBITS-1:0] alu_rd,
    input  logic [LOGSIZE-1:0] alu_data,
    output logic               alu_ready,
    input  logic               mem_valid,
    input  logic [REGBITS-1:0] mem_rd,
    input  logic [LOGSIZE-1:0] mem_data,
    output logic               mem_ready,
    input  logic               wb_flush,
    input  logic               ecall_req,
    input  logic [31:0]        ecall_pc,
    output logic               ecall_start,
    input  logic               ecall_done,
    input  logic [LOGSIZE-1:0] ecall_result,
    output logic               rf_we,
    output logic [REGBITS-1:0] rf_rd,
    output logic [LOGSIZE-1:0] rf_data,
    output logic               ecall_flush,
    output logic [31:0]        pc_after_flush,
    output logic               busy,
    output logic [31:0]        wb_count
);

    typedef enum logic {IDLE, ECALL_WAIT} state_t;
    typedef enum logic {GRANT_ALU, GRANT_MEM} grant_t;

    localparam logic [REGBITS-1:0] A0_REG = REGBITS'(10);

    state_t             state;
    state_t             state_next;
    grant_t             last_grant;
    logic [31:0]        latched_pc;

    logic               grant_alu;
    logic               grant_mem;
    logic               ecall_accept;
    logic               ecall_finish;
    logic               xfer;
    logic [REGBITS-1:0] sel_rd;
    logic [LOGSIZE-1:0] sel_data;
    logic               commit;

    // Handshake: a source transfers in a cycle where its valid and ready are
    // both high; ready is only raised for a source that is offering (valid=1),
    // and valid/payload must be held stable by the source until it transfers.
    always_comb begin
        state_next   = state;
        grant_alu    = 1'b0;
        grant_mem    = 1'b0;
        ecall_accept = 1'b0;
        ecall_finish = 1'b0;
        case (state)
            IDLE: begin
                if (ecall_req) begin
                    if (!wb_flush) begin
                        ecall_accept = 1'b1;
                        state_next   = ECALL_WAIT;
                    end
                end else begin
                    grant_mem = mem_valid && (!alu_valid || last_grant == GRANT_ALU);
                    grant_alu = alu_valid && !grant_mem;
                end
            end
            ECALL_WAIT: begin
                if (ecall_done) begin
                    ecall_finish = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign busy      = (state != IDLE);

    assign xfer     = grant_alu || grant_mem;
    assign sel_rd   = grant_mem ? mem_rd   : alu_rd;
    assign sel_data = grant_mem ? mem_data : alu_data;
    // Writes to x0 are architecturally discarded, so they never reach the port.
    assign commit   = xfer && !wb_flush && (sel_rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_ALU;
        end else if (grant_mem) begin
            last_grant <= GRANT_MEM;
        end else if (grant_alu) begin
            last_grant <= GRANT_ALU;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latched_pc  <= '0;
            ecall_start <= 1'b0;
            ecall_flush <= 1'b0;
        end else begin
            ecall_start <= ecall_accept;
            ecall_flush <= ecall_finish;
            if (ecall_accept) begin
                latched_pc <= ecall_pc;
            end
        end
    end

    // rf_rd/rf_data keep their last written value while rf_we is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we          <= 1'b0;
            rf_rd          <= '0;
            rf_data        <= '0;
            pc_after_flush <= '0;
            wb_count       <= '0;
        end else begin
            rf_we <= 1'b0;
            if (ecall_finish) begin
                rf_we          <= 1'b1;
                rf_rd          <= A0_REG;
                rf_data        <= ecall_result;
                pc_after_flush <= latched_pc + 32'd4;
                wb_count       <= wb_count + 32'd1;
            end else if (commit) begin
                rf_we    <= 1'b1;
                rf_rd    <= sel_rd;
                rf_data  <= sel_data;
                wb_count <= wb_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against a cycle-level
// reference model of the arbitration, commit and ECALL rules.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic        wb_flush;
  logic        ecall_req;
  logic [31:0] ecall_pc;
  logic        ecall_start;
  logic        ecall_done;
  logic [63:0] ecall_result;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_data;
  logic        ecall_flush;
  logic [31:0] pc_after_flush;
  logic        busy;
  logic [31:0] wb_count;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.REGBITS(5), .LOGSIZE(64)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_flush(wb_flush), .ecall_req(ecall_req), .ecall_pc(ecall_pc),
    .ecall_start(ecall_start), .ecall_done(ecall_done), .ecall_result(ecall_result),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .ecall_flush(ecall_flush),
    .pc_after_flush(pc_after_flush), .busy(busy), .wb_count(wb_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit          m_busy;
  bit          m_mem_turn;   // mem wins the next conflict
  logic [31:0] m_pc;
  logic [31:0] m_pc_after;
  logic [31:0] m_count;
  bit          m_we;
  bit          m_start;
  bit          m_flush;
  logic [4:0]  m_rd;
  logic [63:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_mem_turn = 1; m_pc = 0; m_pc_after = 0; m_count = 0;
    m_we = 0; m_start = 0; m_flush = 0; m_rd = 0; m_data = 0;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; wb_flush = 0; ecall_req = 0; ecall_done = 0;
  endtask

  task automatic check_outputs();
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_rd", 64'(rf_rd), 64'(m_rd));
    chk("rf_data", rf_data, m_data);
    chk("ecall_start", 64'(ecall_start), 64'(m_start));
    chk("ecall_flush", 64'(ecall_flush), 64'(m_flush));
    chk("pc_after_flush", 64'(pc_after_flush), 64'(m_pc_after));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("wb_count", 64'(wb_count), 64'(m_count));
  endtask

  // driver: inputs are set at the negedge before calling; returns at next negedge
  task automatic cycle();
    bit          exp_alu_rdy, exp_mem_rdy, nb, we_n, st_n, fl_n;
    logic [4:0]  rd_n, c_rd;
    logic [63:0] d_n, c_data;
    #1;
    exp_alu_rdy = 0; exp_mem_rdy = 0; nb = m_busy;
    we_n = 0; st_n = 0; fl_n = 0; rd_n = m_rd; d_n = m_data; c_rd = 0; c_data = 0;
    if (m_busy) begin
      if (ecall_done) begin
        nb = 0; we_n = 1; rd_n = 5'd10; d_n = ecall_result; fl_n = 1;
        m_pc_after = m_pc + 32'd4;
      end
    end else if (ecall_req) begin
      if (!wb_flush) begin
        nb = 1; st_n = 1; m_pc = ecall_pc;
      end
    end else begin
      if (mem_valid && (!alu_valid || m_mem_turn)) begin
        exp_mem_rdy = 1; c_rd = mem_rd; c_data = mem_data; m_mem_turn = 0;
      end else if (alu_valid) begin
        exp_alu_rdy = 1; c_rd = alu_rd; c_data = alu_data; m_mem_turn = 1;
      end
      if ((exp_alu_rdy || exp_mem_rdy) && !wb_flush && c_rd != 0) begin
        we_n = 1; rd_n = c_rd; d_n = c_data;
      end
    end
    if (we_n) m_count = m_count + 32'd1;
    chk("alu_ready", 64'(alu_ready), 64'(exp_alu_rdy));
    chk("mem_ready", 64'(mem_ready), 64'(exp_mem_rdy));
    @(posedge clk);
    #1;
    m_busy = nb; m_we = we_n; m_start = st_n; m_flush = fl_n; m_rd = rd_n; m_data = d_n;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1; alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0;
    ecall_pc = 0; ecall_result = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 0;
    @(negedge clk);

    // alternating conflict: mem, alu, mem, alu
    alu_valid = 1; mem_valid = 1; alu_rd = 5'd3; mem_rd = 5'd4;
    for (int i = 0; i < 4; i++) begin
      alu_data = {$urandom(), $urandom()};
      mem_data = {$urandom(), $urandom()};
      cycle();
      chk("alt_rf_rd", 64'(rf_rd), (i % 2 == 0) ? 64'd4 : 64'd3);
    end
    chk("alt_wb_count", 64'(wb_count), 64'd4);

    // x0 and flush suppression
    mem_valid = 0; alu_rd = 5'd0; cycle();
    chk("x0_rf_we", 64'(rf_we), 64'd0);
    alu_rd = 5'd5; wb_flush = 1; cycle();
    chk("flush_rf_we", 64'(rf_we), 64'd0);
    idle_inputs(); cycle();
    chk("suppr_wb_count", 64'(wb_count), 64'd4);

    // ECALL with done three cycles after start; alu held valid throughout
    alu_valid = 1; alu_rd = 5'd6; ecall_req = 1; ecall_pc = 32'h100; cycle();
    ecall_req = 0;
    repeat (3) cycle();
    ecall_done = 1; ecall_result = 64'h2A; cycle();
    ecall_done = 0;
    chk("ecall_rf_rd", 64'(rf_rd), 64'd10);
    chk("ecall_rf_data", rf_data, 64'h2A);
    chk("ecall_pc_after", 64'(pc_after_flush), 64'h104);
    chk("ecall_flush_pulse", 64'(ecall_flush), 64'd1);
    cycle();
    alu_valid = 0; cycle();

    // back-to-back: done in the ecall_start cycle
    ecall_req = 1; ecall_pc = $urandom(); cycle();
    ecall_req = 0; ecall_done = 1; ecall_result = {$urandom(), $urandom()};
    alu_valid = 1; alu_rd = 5'd7; alu_data = {$urandom(), $urandom()}; cycle();
    ecall_done = 0; cycle();
    chk("b2b_alu_ready_seen", 64'(busy), 64'd0);
    idle_inputs(); cycle();

    // PC wrap
    ecall_req = 1; ecall_pc = 32'hFFFF_FFFC; cycle();
    ecall_req = 0; ecall_done = 1; cycle();
    ecall_done = 0;
    chk("wrap_pc_after", 64'(pc_after_flush), 64'h0);
    cycle();

    // reset mid-ECALL, then a late ecall_done
    ecall_req = 1; ecall_pc = 32'h200; cycle();
    ecall_req = 0; cycle();
    rst = 1;
    #1;
    model_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    check_outputs();
    @(negedge clk);
    rst = 0;
    ecall_done = 1; cycle();
    ecall_done = 0; cycle();
    chk("rst_wb_count", 64'(wb_count), 64'd0);
    chk("rst_no_redirect", 64'(ecall_flush), 64'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (!alu_valid || alu_ready) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = {$urandom(), $urandom()};
      end
      if (!mem_valid || mem_ready) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = 5'($urandom_range(0, 7));
        mem_data  = {$urandom(), $urandom()};
      end
      wb_flush     = ($urandom_range(0, 7) == 0);
      ecall_req    = ($urandom_range(0, 9) == 0);
      ecall_pc     = $urandom();
      ecall_done   = m_busy && ($urandom_range(0, 2) == 0);
      ecall_result = {$urandom(), $urandom()};
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
